// File: rtl/is_queue_pkg.sv
// rtl/is_queue_pkg.sv - shared constants, opcodes and decoded-entry type for the issue queue
package is_queue_pkg;

    localparam int INS_DAT_W = 32;
    localparam int REG_DAT_W = 32;
    localparam int REG_ADD_W = 5;
    localparam int INS_OP_W  = 5;

    // RV32I major opcodes (ins[6:0])
    localparam logic [6:0] RV_LUI    = 7'b0110111;
    localparam logic [6:0] RV_AUIPC  = 7'b0010111;
    localparam logic [6:0] RV_JAL    = 7'b1101111;
    localparam logic [6:0] RV_JALR   = 7'b1100111;
    localparam logic [6:0] RV_BRANCH = 7'b1100011;
    localparam logic [6:0] RV_LOAD   = 7'b0000011;
    localparam logic [6:0] RV_STORE  = 7'b0100011;
    localparam logic [6:0] RV_OPIMM  = 7'b0010011;
    localparam logic [6:0] RV_OP     = 7'b0110011;

    // Inner opcodes; zero marks an undecodable instruction. Loads and stores
    // share one code each because the 5-bit op field has no room for widths.
    localparam logic [INS_OP_W-1:0] OP_ILL   = 5'd0;
    localparam logic [INS_OP_W-1:0] OP_LUI   = 5'd1;
    localparam logic [INS_OP_W-1:0] OP_AUIPC = 5'd2;
    localparam logic [INS_OP_W-1:0] OP_JAL   = 5'd3;
    localparam logic [INS_OP_W-1:0] OP_JALR  = 5'd4;
    localparam logic [INS_OP_W-1:0] OP_BEQ   = 5'd5;
    localparam logic [INS_OP_W-1:0] OP_BNE   = 5'd6;
    localparam logic [INS_OP_W-1:0] OP_BLT   = 5'd7;
    localparam logic [INS_OP_W-1:0] OP_BGE   = 5'd8;
    localparam logic [INS_OP_W-1:0] OP_BLTU  = 5'd9;
    localparam logic [INS_OP_W-1:0] OP_BGEU  = 5'd10;
    localparam logic [INS_OP_W-1:0] OP_ADDI  = 5'd11;
    localparam logic [INS_OP_W-1:0] OP_SLTI  = 5'd12;
    localparam logic [INS_OP_W-1:0] OP_SLTIU = 5'd13;
    localparam logic [INS_OP_W-1:0] OP_XORI  = 5'd14;
    localparam logic [INS_OP_W-1:0] OP_ORI   = 5'd15;
    localparam logic [INS_OP_W-1:0] OP_ANDI  = 5'd16;
    localparam logic [INS_OP_W-1:0] OP_SLLI  = 5'd17;
    localparam logic [INS_OP_W-1:0] OP_SRLI  = 5'd18;
    localparam logic [INS_OP_W-1:0] OP_SRAI  = 5'd19;
    localparam logic [INS_OP_W-1:0] OP_ADD   = 5'd20;
    localparam logic [INS_OP_W-1:0] OP_SUB   = 5'd21;
    localparam logic [INS_OP_W-1:0] OP_SLL   = 5'd22;
    localparam logic [INS_OP_W-1:0] OP_SLT   = 5'd23;
    localparam logic [INS_OP_W-1:0] OP_SLTU  = 5'd24;
    localparam logic [INS_OP_W-1:0] OP_XOR   = 5'd25;
    localparam logic [INS_OP_W-1:0] OP_SRL   = 5'd26;
    localparam logic [INS_OP_W-1:0] OP_SRA   = 5'd27;
    localparam logic [INS_OP_W-1:0] OP_OR    = 5'd28;
    localparam logic [INS_OP_W-1:0] OP_AND   = 5'd29;
    localparam logic [INS_OP_W-1:0] OP_LD    = 5'd30;
    localparam logic [INS_OP_W-1:0] OP_ST    = 5'd31;

    typedef struct packed {
        logic [INS_OP_W-1:0]  op;
        logic [REG_DAT_W-1:0] imm;
        logic [REG_ADD_W-1:0] rs1;
        logic [REG_ADD_W-1:0] rs2;
        logic [REG_ADD_W-1:0] rd;
        logic                 ils;
        logic                 is;
        logic                 bj;
        logic [REG_DAT_W-1:0] pc;
        logic [REG_DAT_W-1:0] pjt;
    } is_entry_t;

endpackage

// File: rtl/is_decode.sv
// rtl/is_decode.sv - combinational RV32I decoder producing one queue entry
module is_decode
    import is_queue_pkg::*;
(
    input  logic [INS_DAT_W-1:0] ins,
    input  logic                 bj,
    input  logic [REG_DAT_W-1:0] pc,
    input  logic [REG_DAT_W-1:0] pjt,
    output is_entry_t            ent
);

    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [REG_DAT_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};

    // Field extraction per instruction format; unused register fields forced to x0
    always_comb begin
        ent     = '0;
        ent.bj  = bj;
        ent.pc  = pc;
        ent.pjt = pjt;
        ent.rs1 = ins[19:15];
        ent.rs2 = ins[24:20];
        ent.rd  = ins[11:7];
        unique case (ins[6:0])
            RV_LUI, RV_AUIPC: begin
                ent.op  = (ins[6:0] == RV_LUI) ? OP_LUI : OP_AUIPC;
                ent.imm = imm_u;
                ent.rs1 = '0;
                ent.rs2 = '0;
            end
            RV_JAL: begin
                ent.op  = OP_JAL;
                ent.imm = imm_j;
                ent.rs1 = '0;
                ent.rs2 = '0;
            end
            RV_JALR: begin
                ent.op  = (f3 == 3'd0) ? OP_JALR : OP_ILL;
                ent.imm = imm_i;
                ent.rs2 = '0;
            end
            RV_BRANCH: begin
                case (f3)
                    3'd0:    ent.op = OP_BEQ;
                    3'd1:    ent.op = OP_BNE;
                    3'd4:    ent.op = OP_BLT;
                    3'd5:    ent.op = OP_BGE;
                    3'd6:    ent.op = OP_BLTU;
                    3'd7:    ent.op = OP_BGEU;
                    default: ent.op = OP_ILL;
                endcase
                ent.imm = imm_b;
                ent.rd  = '0;
            end
            RV_LOAD: begin
                ent.op  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? OP_ILL : OP_LD;
                ent.imm = imm_i;
                ent.rs2 = '0;
                ent.ils = 1'b1;
            end
            RV_STORE: begin
                ent.op  = (f3 <= 3'd2) ? OP_ST : OP_ILL;
                ent.imm = imm_s;
                ent.rd  = '0;
                ent.ils = 1'b1;
                ent.is  = 1'b1;
            end
            RV_OPIMM: begin
                case (f3)
                    3'd0:    ent.op = OP_ADDI;
                    3'd2:    ent.op = OP_SLTI;
                    3'd3:    ent.op = OP_SLTIU;
                    3'd4:    ent.op = OP_XORI;
                    3'd6:    ent.op = OP_ORI;
                    3'd7:    ent.op = OP_ANDI;
                    3'd1:    ent.op = (f7 == 7'h00) ? OP_SLLI : OP_ILL;
                    default: ent.op = (f7 == 7'h00) ? OP_SRLI :
                                      (f7 == 7'h20) ? OP_SRAI : OP_ILL;
                endcase
                ent.imm = imm_i;
                ent.rs2 = '0;
            end
            RV_OP: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0:    ent.op = OP_ADD;
                        3'd1:    ent.op = OP_SLL;
                        3'd2:    ent.op = OP_SLT;
                        3'd3:    ent.op = OP_SLTU;
                        3'd4:    ent.op = OP_XOR;
                        3'd5:    ent.op = OP_SRL;
                        3'd6:    ent.op = OP_OR;
                        default: ent.op = OP_AND;
                    endcase
                end else if (f7 == 7'h20) begin
                    ent.op = (f3 == 3'd0) ? OP_SUB : (f3 == 3'd5) ? OP_SRA : OP_ILL;
                end else begin
                    ent.op = OP_ILL;
                end
            end
            default: ent.op = OP_ILL;
        endcase
    end

endmodule

// File: rtl/is_queue.sv
// rtl/is_queue.sv - decoded-instruction FIFO between fetch and dispatch
module is_queue
    import is_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iClr,
    input  logic                 iIF_En,
    input  logic [INS_DAT_W-1:0] iIF_Ins,
    input  logic                 iIF_Bj,
    input  logic [REG_DAT_W-1:0] iIF_Pc,
    input  logic [REG_DAT_W-1:0] iIF_Pjt,
    output logic                 oIF_Full,
    input  logic                 iDS_Rdy,
    output logic                 oREG_En,
    output logic [REG_ADD_W-1:0] oREG_Rs1,
    output logic [REG_ADD_W-1:0] oREG_Rs2,
    output logic [REG_ADD_W-1:0] oREG_Rd,
    output logic [INS_OP_W-1:0]  oREG_Op,
    output logic [REG_DAT_W-1:0] oREG_Imm,
    output logic [REG_DAT_W-1:0] oREG_Pc,
    output logic                 oREG_Ils,
    output logic                 oROB_En,
    output logic                 oROB_Is,
    output logic [REG_ADD_W-1:0] oROB_Rd,
    output logic                 oROB_Bj,
    output logic [REG_DAT_W-1:0] oROB_Pc,
    output logic [REG_DAT_W-1:0] oROB_Pjt,
    output logic                 oIll
);

    is_entry_t        dec;
    is_entry_t        iss_q;
    is_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             iss_v, ill_q;
    logic             accept, do_push, do_pop, do_ill;

    is_decode u_decode (
        .ins (iIF_Ins),
        .bj  (iIF_Bj),
        .pc  (iIF_Pc),
        .pjt (iIF_Pjt),
        .ent (dec)
    );

    assign oIF_Full = (count == (PTR_W+1)'(DEPTH));
    assign accept   = en & iIF_En & ~oIF_Full & ~iClr;
    assign do_push  = accept & (dec.op != OP_ILL);
    assign do_ill   = accept & (dec.op == OP_ILL);
    assign do_pop   = en & iDS_Rdy & (count != '0) & ~iClr;

    // Entry storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[tail] <= dec;
    end

    // Pointers, occupancy and the registered issue/illegal outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            iss_v <= 1'b0;
            iss_q <= '0;
            ill_q <= 1'b0;
        end else begin
            iss_v <= 1'b0;
            iss_q <= '0;
            ill_q <= 1'b0;
            if (en && iClr) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (en) begin
                ill_q <= do_ill;
                if (do_pop) begin
                    iss_v <= 1'b1;
                    iss_q <= mem[head];
                    head  <= head + PTR_W'(1);
                end
                if (do_push)
                    tail <= tail + PTR_W'(1);
                if (do_push && !do_pop)
                    count <= count + (PTR_W+1)'(1);
                else if (!do_push && do_pop)
                    count <= count - (PTR_W+1)'(1);
            end
        end
    end

    assign oREG_En  = iss_v;
    assign oREG_Rs1 = iss_q.rs1;
    assign oREG_Rs2 = iss_q.rs2;
    assign oREG_Rd  = iss_q.rd;
    assign oREG_Op  = iss_q.op;
    assign oREG_Imm = iss_q.imm;
    assign oREG_Pc  = iss_q.pc;
    assign oREG_Ils = iss_q.ils;
    assign oROB_En  = iss_v;
    assign oROB_Is  = iss_q.is;
    assign oROB_Rd  = iss_q.rd;
    assign oROB_Bj  = iss_q.bj;
    assign oROB_Pc  = iss_q.pc;
    assign oROB_Pjt = iss_q.pjt;
    assign oIll     = ill_q;

endmodule

// File: tb/tb_is_queue.sv
// tb/tb_is_queue.sv - scoreboard bench for is_queue at DEPTH 4 and DEPTH 2
module tb_is_queue;
    import is_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, iClr, iIF_En, iIF_Bj, iDS_Rdy;
    logic [31:0] iIF_Ins, iIF_Pc, iIF_Pjt;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        full, ill, reg_en, rob_en;
        logic [4:0]  rs1, rs2, rd, op;
        logic [31:0] imm, pc;
        logic        ils, is;
        logic [4:0]  rob_rd;
        logic        bj;
        logic [31:0] rob_pc, pjt;
    } obs_t;

    obs_t o4, o2, o;
    bit   phase2 = 1'b0;
    assign o = phase2 ? o2 : o4;

    is_queue #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .iClr(iClr), .iIF_En(iIF_En), .iIF_Ins(iIF_Ins),
        .iIF_Bj(iIF_Bj), .iIF_Pc(iIF_Pc), .iIF_Pjt(iIF_Pjt), .oIF_Full(o4.full), .iDS_Rdy(iDS_Rdy),
        .oREG_En(o4.reg_en), .oREG_Rs1(o4.rs1), .oREG_Rs2(o4.rs2), .oREG_Rd(o4.rd), .oREG_Op(o4.op),
        .oREG_Imm(o4.imm), .oREG_Pc(o4.pc), .oREG_Ils(o4.ils), .oROB_En(o4.rob_en), .oROB_Is(o4.is),
        .oROB_Rd(o4.rob_rd), .oROB_Bj(o4.bj), .oROB_Pc(o4.rob_pc), .oROB_Pjt(o4.pjt), .oIll(o4.ill)
    );

    is_queue #(.DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .iClr(iClr), .iIF_En(iIF_En), .iIF_Ins(iIF_Ins),
        .iIF_Bj(iIF_Bj), .iIF_Pc(iIF_Pc), .iIF_Pjt(iIF_Pjt), .oIF_Full(o2.full), .iDS_Rdy(iDS_Rdy),
        .oREG_En(o2.reg_en), .oREG_Rs1(o2.rs1), .oREG_Rs2(o2.rs2), .oREG_Rd(o2.rd), .oREG_Op(o2.op),
        .oREG_Imm(o2.imm), .oREG_Pc(o2.pc), .oREG_Ils(o2.ils), .oROB_En(o2.rob_en), .oROB_Is(o2.is),
        .oROB_Rd(o2.rob_rd), .oROB_Bj(o2.bj), .oROB_Pc(o2.rob_pc), .oROB_Pjt(o2.pjt), .oIll(o2.ill)
    );

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  op, rs1, rs2, rd;
        logic [31:0] imm;
        logic        ils, is;
    } vec_t;

    typedef struct {
        logic [4:0]  op, rs1, rs2, rd;
        logic [31:0] imm;
        logic        ils, is, bj;
        logic [31:0] pc, pjt;
    } exp_t;

    vec_t vt [15];
    exp_t sb [$];
    exp_t me;
    int   checks = 0, failures = 0, issued = 0;
    int   mcnt = 0, mdepth = 4, pc_seq = 0, base;
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; the occupancy model decides what the DUT must accept
    task automatic step(input int idx, input logic push, input logic rdy);
        logic acc, pop;
        exp_t e;
        iIF_En  = push;
        iIF_Ins = push ? vt[idx].ins : 32'h0;
        iIF_Pc  = 32'h1000 + 32'(pc_seq * 4);
        iIF_Pjt = iIF_Pc ^ 32'h00ff0000;
        iIF_Bj  = pc_seq[0];
        iDS_Rdy = rdy;
        acc = en && !iClr && !rst && push && (mcnt < mdepth) && (vt[idx].op != 5'd0);
        pop = en && !iClr && !rst && rdy && (mcnt > 0);
        if (acc) begin
            e.op = vt[idx].op;   e.rs1 = vt[idx].rs1; e.rs2 = vt[idx].rs2; e.rd = vt[idx].rd;
            e.imm = vt[idx].imm; e.ils = vt[idx].ils; e.is = vt[idx].is;
            e.bj = iIF_Bj;       e.pc = iIF_Pc;       e.pjt = iIF_Pjt;
            sb.push_back(e);
        end
        mcnt = mcnt + (acc ? 1 : 0) - (pop ? 1 : 0);
        pc_seq++;
        tick();
    endtask

    // Monitor: every issued instruction must match the oldest expected entry
    always @(negedge clk) begin
        if (mon_on) begin
            chk("rob_en_vs_reg_en", 32'(o.rob_en), 32'(o.reg_en));
            if (o.reg_en) begin
                issued++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_issue: got op=%0d pc=%h expected no issue", o.op, o.pc);
                end else begin
                    me = sb.pop_front();
                    if ({o.op, o.rs1, o.rs2, o.rd, o.imm, o.ils, o.is, o.bj, o.pc, o.pjt, o.rob_rd, o.rob_pc} !==
                        {me.op, me.rs1, me.rs2, me.rd, me.imm, me.ils, me.is, me.bj, me.pc, me.pjt, me.rd, me.pc}) begin
                        failures++;
                        $display("FAIL issue_fields: got op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ils=%0d is=%0d bj=%0d pc=%h pjt=%h rob_rd=%0d rob_pc=%h expected op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ils=%0d is=%0d bj=%0d pc=%h pjt=%h",
                                 o.op, o.rs1, o.rs2, o.rd, o.imm, o.ils, o.is, o.bj, o.pc, o.pjt, o.rob_rd, o.rob_pc,
                                 me.op, me.rs1, me.rs2, me.rd, me.imm, me.ils, me.is, me.bj, me.pc, me.pjt);
                    end
                end
            end else begin
                chk("idle_data_zero", 32'(|{o.rs1, o.rs2, o.rd, o.op, o.imm, o.pc, o.ils, o.is, o.rob_rd, o.bj, o.rob_pc, o.pjt}), 32'd0);
            end
        end
    end

    initial begin
        vt[0]  = '{32'h00500093, OP_ADDI, 5'd0, 5'd0, 5'd1, 32'h00000005, 1'b0, 1'b0};
        vt[1]  = '{32'h00100093, OP_ADDI, 5'd0, 5'd0, 5'd1, 32'h00000001, 1'b0, 1'b0};
        vt[2]  = '{32'h00200113, OP_ADDI, 5'd0, 5'd0, 5'd2, 32'h00000002, 1'b0, 1'b0};
        vt[3]  = '{32'h00300193, OP_ADDI, 5'd0, 5'd0, 5'd3, 32'h00000003, 1'b0, 1'b0};
        vt[4]  = '{32'h00400213, OP_ADDI, 5'd0, 5'd0, 5'd4, 32'h00000004, 1'b0, 1'b0};
        vt[5]  = '{32'h00500293, OP_ADDI, 5'd0, 5'd0, 5'd5, 32'h00000005, 1'b0, 1'b0};
        vt[6]  = '{32'h40208033, OP_SUB,  5'd1, 5'd2, 5'd0, 32'h00000000, 1'b0, 1'b0};
        vt[7]  = '{32'hFFF00113, OP_ADDI, 5'd0, 5'd0, 5'd2, 32'hFFFFFFFF, 1'b0, 1'b0};
        vt[8]  = '{32'h0000006F, OP_JAL,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0};
        vt[9]  = '{32'h00000000, 5'd0,    5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0};
        vt[10] = '{32'h123453B7, OP_LUI,  5'd0, 5'd0, 5'd7, 32'h12345000, 1'b0, 1'b0};
        vt[11] = '{32'h0020A423, OP_ST,   5'd1, 5'd2, 5'd0, 32'h00000008, 1'b1, 1'b1};
        vt[12] = '{32'hFFC0A183, OP_LD,   5'd1, 5'd0, 5'd3, 32'hFFFFFFFC, 1'b1, 1'b0};
        vt[13] = '{32'h00208463, OP_BEQ,  5'd1, 5'd2, 5'd0, 32'h00000008, 1'b0, 1'b0};
        vt[14] = '{32'h4030D213, OP_SRAI, 5'd1, 5'd0, 5'd4, 32'h00000403, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b1; iClr = 1'b0; iIF_En = 1'b0; iIF_Ins = '0;
        iIF_Pc = '0; iIF_Pjt = '0; iIF_Bj = 1'b0; iDS_Rdy = 1'b0;
        tick(); tick();
        chk("reset_full", 32'(o.full), 32'd0);
        chk("reset_reg_en", 32'(o.reg_en), 32'd0);
        chk("reset_ill", 32'(o.ill), 32'd0);
        rst = 1'b0;
        mon_on = 1'b1;

        // ADDI x1,x0,5 with dispatch ready: no bypass, issues one edge later
        step(0, 1'b1, 1'b1);
        chk("no_bypass", 32'(o.reg_en), 32'd0);
        step(0, 1'b0, 1'b1);
        chk("issue_latency", 32'(o.reg_en), 32'd1);

        // Fill with dispatch stalled; fifth push refused, then four drain in order
        for (int i = 1; i <= 5; i++) begin
            step(i, 1'b1, 1'b0);
            if (i == 3) chk("full_after_3", 32'(o.full), 32'd0);
            if (i == 4) chk("full_after_4", 32'(o.full), 32'd1);
        end
        chk("full_after_5", 32'(o.full), 32'd1);
        base = issued;
        for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b1);
        chk("drain_count", 32'(issued - base), 32'd4);
        chk("drained_full", 32'(o.full), 32'd0);

        // SUB, ADDI -1, JAL
        for (int i = 6; i <= 8; i++) step(i, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1);

        // Illegal instruction: one-cycle pulse, not stored
        step(1, 1'b1, 1'b0);
        step(9, 1'b1, 1'b0);
        chk("ill_pulse", 32'(o.ill), 32'd1);
        step(0, 1'b0, 1'b0);
        chk("ill_one_cycle", 32'(o.ill), 32'd0);
        step(2, 1'b1, 1'b0);
        step(3, 1'b1, 1'b0);
        chk("ill_not_counted", 32'(o.full), 32'd0);

        // Flush with three queued and a same-cycle push
        iClr = 1'b1;
        step(4, 1'b1, 1'b1);
        iClr = 1'b0;
        sb.delete();
        mcnt = 0;
        chk("clr_full", 32'(o.full), 32'd0);
        chk("clr_no_issue", 32'(o.reg_en), 32'd0);
        chk("clr_no_ill", 32'(o.ill), 32'd0);
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1);
        for (int i = 10; i <= 13; i++) step(i, 1'b1, 1'b0);
        chk("refill_full", 32'(o.full), 32'd1);

        // Full queue: push refused even while a pop happens
        step(14, 1'b1, 1'b1);
        chk("full_push_refused", 32'(o.full), 32'd0);

        // Global hold
        en = 1'b0;
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1);
        chk("hold_no_issue", 32'(o.reg_en), 32'd0);
        chk("hold_full", 32'(o.full), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1);
        chk("phase1_sb_empty", 32'(sb.size()), 32'd0);

        // DEPTH=2 wrap-around with random dispatch readiness and a mid-stream reset
        mon_on = 1'b0;
        phase2 = 1'b1;
        mdepth = 2;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mcnt = 0;
        sb.delete();
        mon_on = 1'b1;
        for (int k = 0; k < 10; k++) step(10 + (k % 5), 1'((k % 4) != 3), 1'($urandom_range(0, 1)));
        rst = 1'b1;
        step(10, 1'b1, 1'b1);
        rst = 1'b0;
        sb.delete();
        mcnt = 0;
        chk("rst_mid_full", 32'(o.full), 32'd0);
        chk("rst_mid_no_issue", 32'(o.reg_en), 32'd0);
        step(0, 1'b0, 1'b1);
        chk("rst_mid_next_idle", 32'(o.reg_en), 32'd0);
        for (int k = 0; k < 6; k++) step(6 + (k % 3), 1'b1, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 4; k++) step(0, 1'b0, 1'b1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_full", 32'(o.full), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
